// File: rtl/jesd204b_pkg.sv
// rtl/jesd204b_pkg.sv - shared K-characters, link state encoding and ILAS length for the JESD204B TX link
package jesd204b_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K28_0 = 8'h1C;
   localparam logic [7:0] K28_3 = 8'h7C;
   localparam logic [7:0] K28_4 = 8'h9C;

   localparam int ILAS_MF_COUNT = 4;

   typedef enum logic [1:0] {
      CGS  = 2'd0,
      ILAS = 2'd1,
      DATA = 2'd2
   } link_state_t;

endpackage

// File: rtl/jesd204b_tx_link_if.sv
// rtl/jesd204b_tx_link_if.sv - framer-side data/ready and encoder-side lane bundle of the JESD204B TX link
interface jesd204b_tx_link_if #(
   parameter int LANES = 4
);
   logic [LANES*32-1:0] tx_data;
   logic                tx_ready;
   logic [LANES*32-1:0] tx_lane_data;
   logic [LANES*4-1:0]  tx_lane_charisk;
   logic                lmfc_wrap;

   modport master (
      output tx_data,
      input  tx_ready, tx_lane_data, tx_lane_charisk, lmfc_wrap
   );

   modport slave (
      input  tx_data,
      output tx_ready, tx_lane_data, tx_lane_charisk, lmfc_wrap
   );
endinterface

// File: rtl/jesd204b_tx_scrambler.sv
// rtl/jesd204b_tx_scrambler.sv - one lane of the 1+x^14+x^15 self-synchronising scrambler, 32 bits per clock
module jesd204b_tx_scrambler (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] din,
   output logic [31:0] dout
);

   logic [14:0] scr_state;
   logic [14:0] hist;

   // Serial scrambling unrolled over the word; hist[0] is the newest scrambled bit.
   // Octet 0 goes first, each octet MSB first.
   always_comb begin
      logic sb;
      int   idx;
      hist = scr_state;
      dout = '0;
      sb   = 1'b0;
      idx  = 0;
      for (int k = 0; k < 32; k++) begin
         idx       = 8 * (k / 8) + 7 - (k % 8);
         sb        = din[idx] ^ hist[13] ^ hist[14];
         dout[idx] = sb;
         hist      = {hist[13:0], sb};
      end
   end

   // Scrambler history; reloaded to the seed whenever the link enters DATA.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)    scr_state <= 15'h7F80;
      else if (load) scr_state <= 15'h7F80;
      else           scr_state <= hist;
   end

endmodule

// File: rtl/jesd204b_tx_link.sv
// rtl/jesd204b_tx_link.sv - JESD204B TX link sequencer (CGS/ILAS/DATA, LMFC); macro JESD204B_TX_SCRAMBLE_EN adds DATA scrambling
module jesd204b_tx_link
   import jesd204b_pkg::*;
#(
   parameter int           LANES    = 4,
   parameter int           F        = 2,
   parameter int           K        = 16,
   parameter logic [111:0] ILAS_CFG = 112'h0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sync_n,
   jesd204b_tx_link_if.slave link
);

   localparam int MF_OCTETS = F * K;
   localparam int MF_WORDS  = MF_OCTETS / 4;
   localparam int CNT_W     = $clog2(MF_WORDS);
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(MF_WORDS - 1);
   localparam logic [1:0]       LAST_MF   = 2'(ILAS_MF_COUNT - 1);

   logic                sync_meta, sync_s;
   link_state_t         state, state_next;
   logic [CNT_W-1:0]    lmfc_cnt;
   logic                lmfc_last;
   logic [1:0]          ilas_mf;
   logic [31:0]         ilas_word;
   logic [3:0]          ilas_k;
   logic [LANES*32-1:0] data_word;
   logic [LANES*32-1:0] mux_data, lane_data_q;
   logic [LANES*4-1:0]  mux_k, lane_k_q;
   logic                tx_ready_q;

   assign lmfc_last = (lmfc_cnt == LAST_WORD);

   // Two-flop synchroniser for the receiver's SYNC~; resets to "CGS requested".
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_meta <= 1'b0;
         sync_s    <= 1'b0;
      end else begin
         sync_meta <= sync_n;
         sync_s    <= sync_meta;
      end
   end

   // Free-running LMFC word counter, independent of link state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)         lmfc_cnt <= '0;
      else if (lmfc_last) lmfc_cnt <= '0;
      else                lmfc_cnt <= lmfc_cnt + CNT_W'(1);
   end

   // Link state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= CGS;
      else        state <= state_next;
   end

   // Next state: ILAS starts on an LMFC boundary, a dropped SYNC~ aborts at once.
   always_comb begin
      state_next = state;
      case (state)
         CGS:     if (sync_s && lmfc_last) state_next = ILAS;
         ILAS:    if (!sync_s) state_next = CGS;
                  else if (lmfc_last && ilas_mf == LAST_MF) state_next = DATA;
         DATA:    if (!sync_s) state_next = CGS;
         default: state_next = CGS;
      endcase
   end

   // ILAS multiframe index; cleared whenever the link is not staying in ILAS.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                          ilas_mf <= '0;
      else if (state_next != ILAS)         ilas_mf <= '0;
      else if (state == ILAS && lmfc_last) ilas_mf <= ilas_mf + 2'd1;
   end

   // ILAS octets for the current LMFC word, identical on every lane.
   always_comb begin
      logic [111:0] cfg_sh;
      int           n;
      ilas_word = '0;
      ilas_k    = '0;
      cfg_sh    = '0;
      n         = 0;
      for (int j = 0; j < 4; j++) begin
         n                  = int'(lmfc_cnt) * 4 + j;
         ilas_word[8*j +: 8] = 8'(n);
         ilas_k[j]           = 1'b0;
         if (n == 0) begin
            ilas_word[8*j +: 8] = K28_0;
            ilas_k[j]           = 1'b1;
         end else if (n == MF_OCTETS - 1) begin
            ilas_word[8*j +: 8] = K28_3;
            ilas_k[j]           = 1'b1;
         end else if (ilas_mf == 2'd1 && n == 1) begin
            ilas_word[8*j +: 8] = K28_4;
            ilas_k[j]           = 1'b1;
         end else if (ilas_mf == 2'd1 && n >= 2 && n <= 15) begin
            cfg_sh              = ILAS_CFG >> (8 * (n - 2));
            ilas_word[8*j +: 8] = cfg_sh[7:0];
         end
      end
   end

`ifdef JESD204B_TX_SCRAMBLE_EN
   logic scr_load;
   assign scr_load = (state_next == DATA) && (state != DATA);

   for (genvar l = 0; l < LANES; l++) begin : g_scr
      jesd204b_tx_scrambler u_scr (
         .clock (clock),
         .reset (reset),
         .load  (scr_load),
         .din   (link.tx_data[l*32 +: 32]),
         .dout  (data_word[l*32 +: 32])
      );
   end
`else
   assign data_word = link.tx_data;
`endif

   // Octet mux: an imminent return to CGS already sends K28.5.
   always_comb begin
      mux_data = '0;
      mux_k    = '0;
      if (state == CGS || state_next == CGS) begin
         mux_data = {(LANES*4){K28_5}};
         mux_k    = '1;
      end else if (state == ILAS) begin
         mux_data = {LANES{ilas_word}};
         mux_k    = {LANES{ilas_k}};
      end else begin
         mux_data = data_word;
      end
   end

   // Registered lane outputs; tx_ready follows the state the link enters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lane_data_q <= '0;
         lane_k_q    <= '0;
         tx_ready_q  <= 1'b0;
      end else begin
         lane_data_q <= mux_data;
         lane_k_q    <= mux_k;
         tx_ready_q  <= (state_next == DATA);
      end
   end

   assign link.tx_lane_data    = lane_data_q;
   assign link.tx_lane_charisk = lane_k_q;
   assign link.tx_ready        = tx_ready_q;
   assign link.lmfc_wrap       = lmfc_last;

endmodule

// File: tb/tb_jesd204b_tx_link.sv
// tb/tb_jesd204b_tx_link.sv - directed self-checking bench for jesd204b_tx_link (LANES=4, F=2, K=16)
module tb_jesd204b_tx_link;

   logic clk;
   logic rst_n;
   logic sync_n;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   waited;

   jesd204b_tx_link_if #(.LANES(4)) lnk ();

   jesd204b_tx_link #(
      .LANES    (4),
      .F        (2),
      .K        (16),
      .ILAS_CFG (112'h0D0C0B0A090807060504030201_00)
   ) dut (
      .clock  (clk),
      .reset  (rst_n),
      .sync_n (sync_n),
      .link   (lnk.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Edges from a sync_n rise (just after edge r) until the first ILAS word is visible.
   function automatic int exp_wait(input int r);
      int e;
      e = r + 3;
      while (((e - 1) % 8) != 7) e++;
      return e + 1 - r;
   endfunction

   task automatic wait_ilas(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (lnk.tx_lane_charisk == 16'hFFFF && n < 30);
      if (lnk.tx_lane_charisk == 16'hFFFF) n = -1;
   endtask

`ifdef JESD204B_TX_SCRAMBLE_EN
   logic [14:0] mst [4];

   // Reference: each bit is XORed with the scrambled bits 14 and 15 positions earlier.
   task automatic model_word(input logic [127:0] d, output logic [127:0] q);
      logic b;
      q = '0;
      for (int l = 0; l < 4; l++)
         for (int o = 0; o < 4; o++)
            for (int bi = 7; bi >= 0; bi--) begin
               b = d[l*32 + o*8 + bi] ^ mst[l][13] ^ mst[l][14];
               q[l*32 + o*8 + bi] = b;
               mst[l] = {mst[l][13:0], b};
            end
   endtask
`else
   task automatic model_word(input logic [127:0] d, output logic [127:0] q);
      q = d;
   endtask
`endif

   logic [127:0] v0, v1, v2, exp_d;

   initial begin
      v0 = {32'hCAFEF00D, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};
      v1 = {32'h00000000, 32'hFFFFFFFF, 32'hA5A55A5A, 32'h12345678};
      v2 = {32'h0F0F0F0F, 32'hF0F0F0F0, 32'h11223344, 32'h55667788};
      rst_n = 1'b0;
      sync_n = 1'b0;
      lnk.tx_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_data", lnk.tx_lane_data, '0);
      check_eq("rst_k", lnk.tx_lane_charisk, '0);
      check_eq("rst_ready", lnk.tx_ready, 1'b0);
      check_eq("rst_wrap", lnk.lmfc_wrap, 1'b0);
      rst_n = 1'b1;
      cyc = 0;

      for (int i = 1; i <= 16; i++) begin
         step();
         check_eq("cgs_data", lnk.tx_lane_data, {16{8'hBC}});
         check_eq("cgs_k", lnk.tx_lane_charisk, 16'hFFFF);
         check_eq("cgs_ready", lnk.tx_ready, 1'b0);
         check_eq("cgs_wrap", lnk.lmfc_wrap, (i % 8) == 7);
      end

      sync_n = 1'b1;
      wait_ilas(waited);
      check_eq("ilas_align", waited, 9);
      check_eq("ilas_w0", lnk.tx_lane_data, {4{32'h0302011C}});
      check_eq("ilas_w0_k", lnk.tx_lane_charisk, {4{4'b0001}});
      check_eq("ilas_ready", lnk.tx_ready, 1'b0);

      for (int w = 1; w < 32; w++) begin
         step();
         check_eq("ilas_wrap", lnk.lmfc_wrap, (w % 8) == 6);
         case (w)
            7, 31: begin
               check_eq("ilas_a", lnk.tx_lane_data, {4{32'h7C1E1D1C}});
               check_eq("ilas_a_k", lnk.tx_lane_charisk, {4{4'b1000}});
            end
            8: begin
               check_eq("ilas_q", lnk.tx_lane_data, {4{32'h01009C1C}});
               check_eq("ilas_q_k", lnk.tx_lane_charisk, {4{4'b0011}});
            end
            9: begin
               check_eq("ilas_cfg1", lnk.tx_lane_data, {4{32'h05040302}});
               check_eq("ilas_cfg1_k", lnk.tx_lane_charisk, 16'h0);
            end
            10: check_eq("ilas_cfg2", lnk.tx_lane_data, {4{32'h09080706}});
            11: check_eq("ilas_cfg3", lnk.tx_lane_data, {4{32'h0D0C0B0A}});
            12: begin
               check_eq("ilas_mf1_w4", lnk.tx_lane_data, {4{32'h13121110}});
               check_eq("ilas_mf1_w4_k", lnk.tx_lane_charisk, 16'h0);
            end
            16, 24: begin
               check_eq("ilas_r", lnk.tx_lane_data, {4{32'h0302011C}});
               check_eq("ilas_r_k", lnk.tx_lane_charisk, {4{4'b0001}});
            end
            30: check_eq("ilas_end_ready", lnk.tx_ready, 1'b0);
            default: ;
         endcase
      end
      check_eq("data_ready", lnk.tx_ready, 1'b1);

`ifdef JESD204B_TX_SCRAMBLE_EN
      for (int l = 0; l < 4; l++) mst[l] = 15'h7F80;
`endif
      lnk.tx_data = v0;
      step();
      model_word(v0, exp_d);
      check_eq("data_v0", lnk.tx_lane_data, exp_d);
      check_eq("data_v0_k", lnk.tx_lane_charisk, 16'h0);
      check_eq("data_v0_ready", lnk.tx_ready, 1'b1);
      lnk.tx_data = v1;
      step();
      model_word(v1, exp_d);
      check_eq("data_v1", lnk.tx_lane_data, exp_d);

      lnk.tx_data = v2;
      sync_n = 1'b0;
      step();
      check_eq("drop_e1_ready", lnk.tx_ready, 1'b1);
      step();
      check_eq("drop_e2_ready", lnk.tx_ready, 1'b1);
      step();
      check_eq("drop_data", lnk.tx_lane_data, {16{8'hBC}});
      check_eq("drop_k", lnk.tx_lane_charisk, 16'hFFFF);
      check_eq("drop_ready", lnk.tx_ready, 1'b0);

      sync_n = 1'b1;
      begin
         int r;
         r = cyc;
         wait_ilas(waited);
         check_eq("reilas_align", waited, exp_wait(r));
      end
      check_eq("reilas_w0", lnk.tx_lane_data, {4{32'h0302011C}});
      check_eq("reilas_w0_k", lnk.tx_lane_charisk, {4{4'b0001}});

      step();
      step();
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("arst_data", lnk.tx_lane_data, '0);
      check_eq("arst_k", lnk.tx_lane_charisk, '0);
      check_eq("arst_ready", lnk.tx_ready, 1'b0);
      #1;
      rst_n = 1'b1;
      cyc = 0;
      for (int i = 1; i <= 8; i++) begin
         step();
         check_eq("post_data", lnk.tx_lane_data, {16{8'hBC}});
         check_eq("post_wrap", lnk.lmfc_wrap, i == 7);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
